snn_activation_array: RTL and testbench

Parametrised, multi-channel integrate-and-fire activation stage for the spiking datapath. Each channel integrates a signed input current into a persistent membrane register, compares it against a shared threshold, emits a spike, and counts spikes in a saturating counter over a programmable window of timesteps. A start/done window controller and a valid/ready input handshake frame each inference, and the block sits between the PE-array partial-sum outputs and the spike-count readout.

---
 rtl/snn_activation_array.sv | 172 +++++++++++++++++
 tb/tb_snn_activation_array.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/snn_activation_array.sv
// snn_activation_array: multi-channel integrate-and-fire activation stage.
// Each channel adds a signed input current to its membrane register (saturating),
// fires when the membrane reaches the shared threshold, and counts spikes in a
// saturating counter over a window of num_steps accepted beats.
// Build option: define SNN_SOFT_RESET_EN for reset-by-subtraction on fire;
// leave it undefined for hard reset to zero.
module snn_activation_array #(
  parameter int NUM_CH      = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 8,
  parameter int STEP_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [STEP_WIDTH-1:0]        num_steps,
  input  logic [DATA_WIDTH-1:0]        threshold,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] current,
  output logic [NUM_CH-1:0]            spikes,
  output logic                         spike_valid,
  output logic [NUM_CH*COUNT_WIDTH-1:0] counts,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic signed [DATA_WIDTH-1:0] D_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] D_MIN    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [STEP_WIDTH-1:0]        STEP_ONE = {{(STEP_WIDTH-1){1'b0}}, 1'b1};

  state_t                        state;
  logic [STEP_WIDTH-1:0]         step;
  logic [STEP_WIDTH-1:0]         num_steps_q;
  logic signed [DATA_WIDTH-1:0]  threshold_q;
  logic signed [DATA_WIDTH-1:0]  membrane [NUM_CH];
  logic [COUNT_WIDTH-1:0]        count    [NUM_CH];

  logic signed [DATA_WIDTH-1:0]  v_next   [NUM_CH];
  logic [COUNT_WIDTH-1:0]        c_next   [NUM_CH];
  logic [NUM_CH-1:0]             fire;

  logic signed [DATA_WIDTH-1:0]  cur_i;
  logic signed [DATA_WIDTH:0]    sum_w;
  logic signed [DATA_WIDTH-1:0]  s_i;
  logic signed [DATA_WIDTH-1:0]  reset_val;
`ifdef SNN_SOFT_RESET_EN
  logic signed [DATA_WIDTH:0]    diff_w;
`endif

  logic accept;
  logic last_beat;

  // Clamp a one-bit-wider signed result back into the signed DATA_WIDTH range.
  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH:0] x);
    if (x[DATA_WIDTH] != x[DATA_WIDTH-1]) begin
      sat = x[DATA_WIDTH] ? D_MIN : D_MAX;
    end else begin
      sat = x[DATA_WIDTH-1:0];
    end
  endfunction

  assign accept    = (state == S_RUN) && in_valid;
  assign last_beat = (step == num_steps_q - STEP_ONE);
  assign in_ready  = (state == S_RUN);
  assign busy      = (state != S_IDLE);

  // Per-channel integrate, fire decision, membrane reset value and counter update.
  always_comb begin
    // NOTE: every combinational output gets a value on every path (defaults first), otherwise a latch is inferred.
    fire      = '0;
    cur_i     = '0;
    sum_w     = '0;
    s_i       = '0;
    reset_val = '0;
`ifdef SNN_SOFT_RESET_EN
    diff_w    = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      cur_i   = current[i*DATA_WIDTH +: DATA_WIDTH];
      sum_w   = {cur_i[DATA_WIDTH-1], cur_i} + {membrane[i][DATA_WIDTH-1], membrane[i]};
      s_i     = sat(sum_w);
      fire[i] = (s_i >= threshold_q);
`ifdef SNN_SOFT_RESET_EN
      // Residual above threshold is kept; a negative threshold can push it past max.
      diff_w    = {s_i[DATA_WIDTH-1], s_i} - {threshold_q[DATA_WIDTH-1], threshold_q};
      reset_val = sat(diff_w);
`else
      reset_val = '0;
`endif
      v_next[i] = fire[i] ? reset_val : s_i;
      c_next[i] = (&count[i]) ? count[i] : count[i] + COUNT_WIDTH'(fire[i]);
    end
  end

  // Pack per-channel counters onto the flat output bus.
  always_comb begin
    counts = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      counts[i*COUNT_WIDTH +: COUNT_WIDTH] = count[i];
    end
  end

  // Window FSM plus all datapath state; pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      step        <= '0;
      num_steps_q <= '0;
      threshold_q <= '0;
      spikes      <= '0;
      spike_valid <= 1'b0;
      done        <= 1'b0;
      // NOTE: membranes and counters are small flop arrays, not RAM, so resetting them costs nothing special.
      for (int i = 0; i < NUM_CH; i++) begin
        membrane[i] <= '0;
        count[i]    <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      spike_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            step        <= '0;
            num_steps_q <= num_steps;
            threshold_q <= threshold;
            for (int i = 0; i < NUM_CH; i++) begin
              membrane[i] <= '0;
              count[i]    <= '0;
            end
            if (num_steps == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            for (int i = 0; i < NUM_CH; i++) begin
              membrane[i] <= v_next[i];
              count[i]    <= c_next[i];
            end
            spikes      <= fire;
            spike_valid <= 1'b1;
            step        <= step + STEP_ONE;
            if (last_beat) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snn_activation_array.sv
// Testbench for snn_activation_array: table of per-cycle stimulus and expected
// outputs on a 3-channel instance, plus a counter-saturation sequence on a
// 1-channel instance with 2-bit counters.
module tb_snn_activation_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_steps;
  logic [15:0] threshold;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] current;
  logic [2:0]  spikes;
  logic        spike_valid;
  logic [23:0] counts;
  logic        busy;
  logic        done;

  logic        s_start;
  logic [7:0]  s_num_steps;
  logic [15:0] s_threshold;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [15:0] s_current;
  logic [0:0]  s_spikes;
  logic        s_spike_valid;
  logic [1:0]  s_counts;
  logic        s_busy;
  logic        s_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  snn_activation_array u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_steps   (num_steps),
    .threshold   (threshold),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .current     (current),
    .spikes      (spikes),
    .spike_valid (spike_valid),
    .counts      (counts),
    .busy        (busy),
    .done        (done)
  );

  snn_activation_array #(
    .NUM_CH      (1),
    .DATA_WIDTH  (16),
    .COUNT_WIDTH (2),
    .STEP_WIDTH  (8)
  ) u_sat (
    .clk         (clk),
    .rst         (rst),
    .start       (s_start),
    .num_steps   (s_num_steps),
    .threshold   (s_threshold),
    .in_valid    (s_in_valid),
    .in_ready    (s_in_ready),
    .current     (s_current),
    .spikes      (s_spikes),
    .spike_valid (s_spike_valid),
    .counts      (s_counts),
    .busy        (s_busy),
    .done        (s_done)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        start;
    logic [7:0]  ns;
    logic [15:0] thr;
    logic        vld;
    logic [47:0] cur;
    logic        busy;
    logic        rdy;
    logic        sv;
    logic        chk_spk;
    logic [2:0]  spk;
    logic [23:0] cnt;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  // Fire pattern of a channel fed 7 per beat against threshold 10, beat 1 at bit 0.
`ifdef SNN_SOFT_RESET_EN
  localparam logic [9:0] FIRE_MASK_7 = 10'b1110110110;
`else
  localparam logic [9:0] FIRE_MASK_7 = 10'b1010101010;
`endif

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic r, input logic st, input int ns, input int thr,
                     input logic vld, input int c0, input int c1, input int c2,
                     input logic e_busy, input logic e_rdy, input logic e_sv, input logic e_chk,
                     input logic [2:0] e_spk, input int n0, input int n1, input int n2,
                     input logic e_done);
    vec_t v;
    v.name    = name;
    v.rst     = r;
    v.start   = st;
    v.ns      = 8'(ns);
    v.thr     = 16'(thr);
    v.vld     = vld;
    v.cur     = {16'(c2), 16'(c1), 16'(c0)};
    v.busy    = e_busy;
    v.rdy     = e_rdy;
    v.sv      = e_sv;
    v.chk_spk = e_chk;
    v.spk     = e_spk;
    v.cnt     = {8'(n2), 8'(n1), 8'(n0)};
    v.done    = e_done;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    rst = 1'b1; start = 1'b0; num_steps = '0; threshold = '0; in_valid = 1'b0; current = '0;
    s_start = 1'b0; s_num_steps = '0; s_threshold = '0; s_in_valid = 1'b0; s_current = '0;

    // name            rst st ns thr   vld c0 c1 c2      busy rdy sv chk spk   n0 n1 n2 done
    add("rst",          1, 0, 0, 0,    0,  0, 0, 0,      0,   0,  0, 1,  3'b000, 0, 0, 0, 0);
    // Hard/soft identical here: ch0 fires on beat 3 only, ch1 every beat, ch2 never.
    add("a_start",      0, 1, 4, 10,   0,  4, 10, 0,     1,   1,  0, 0,  3'b000, 0, 0, 0, 0);
    add("a_b1",         0, 0, 0, 99,   1,  4, 10, 0,     1,   1,  1, 1,  3'b010, 0, 1, 0, 0);
    add("a_b2",         0, 0, 0, 99,   1,  4, 10, 0,     1,   1,  1, 1,  3'b010, 0, 2, 0, 0);
    add("a_b3",         0, 0, 0, 99,   1,  4, 10, 0,     1,   1,  1, 1,  3'b011, 1, 3, 0, 0);
    add("a_b4",         0, 0, 0, 99,   1,  4, 10, 0,     1,   0,  1, 1,  3'b010, 1, 4, 0, 1);
    add("a_idle",       0, 0, 0, 99,   0,  4, 10, 0,     0,   0,  0, 0,  3'b000, 1, 4, 0, 0);

    // Reset-mode sequence: current 7, threshold 10, ten beats.
    add("b_start",      0, 1, 10, 10,  0,  7, 0, 0,      1,   1,  0, 0,  3'b000, 0, 0, 0, 0);
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      acc += int'(FIRE_MASK_7[k]);
      add($sformatf("b_b%0d", k + 1), 0, 0, 0, 500, 1, 7, 0, 0,
          1, (k != 9), 1, 1, {2'b00, FIRE_MASK_7[k]}, acc, 0, 0, (k == 9));
    end
    add("b_idle",       0, 0, 0, 500,  0,  7, 0, 0,      0,   0,  0, 0,  3'b000, acc, 0, 0, 0);

    // Membrane saturation at the positive and negative rails.
    add("c_start",      0, 1, 3, 32767, 0, 0, 0, 0,      1,   1,  0, 0,  3'b000, 0, 0, 0, 0);
    add("c_b1",         0, 0, 0, 0,    1, 16384, -32768, 0, 1, 1, 1, 1,  3'b000, 0, 0, 0, 0);
    add("c_b2",         0, 0, 0, 0,    1, 32767, -32768, 0, 1, 1, 1, 1,  3'b001, 1, 0, 0, 0);
    add("c_b3",         0, 0, 0, 0,    1, 32767, -32768, 0, 1, 0, 1, 1,  3'b001, 2, 0, 0, 1);
    add("c_idle",       0, 0, 0, 0,    0,  0, 0, 0,      0,   0,  0, 0,  3'b000, 2, 0, 0, 0);

    // Negative threshold: signed compare, and negative rail must not wrap to 0.
    add("d_start",      0, 1, 2, -100, 0,  0, -32768, 50, 1,  1,  0, 0,  3'b000, 0, 0, 0, 0);
    add("d_b1",         0, 0, 0, 1000, 1,  0, -32768, 50, 1,  1,  1, 1,  3'b101, 1, 0, 1, 0);
    add("d_b2",         0, 0, 0, 1000, 1,  0, -32768, 50, 1,  0,  1, 1,  3'b101, 2, 0, 2, 1);
    add("d_idle",       0, 0, 0, 1000, 0,  0, 0, 0,      0,   0,  0, 0,  3'b000, 2, 0, 2, 0);

    // Backpressure with in_valid 1,0,0,1 and a start pulse during RUN.
    add("e_start",      0, 1, 2, 10,   0, 10, 0, 0,      1,   1,  0, 0,  3'b000, 0, 0, 0, 0);
    add("e_b1",         0, 0, 0, 10,   1, 10, 0, 0,      1,   1,  1, 1,  3'b001, 1, 0, 0, 0);
    add("e_gap1",       0, 0, 0, 10,   0, 10, 0, 0,      1,   1,  0, 0,  3'b000, 1, 0, 0, 0);
    add("e_gap2_start", 0, 1, 9, 10,   0, 10, 0, 0,      1,   1,  0, 0,  3'b000, 1, 0, 0, 0);
    add("e_b2",         0, 0, 0, 10,   1, 10, 0, 0,      1,   0,  1, 1,  3'b001, 2, 0, 0, 1);
    add("e_idle",       0, 0, 0, 10,   0, 10, 0, 0,      0,   0,  0, 0,  3'b000, 2, 0, 0, 0);

    // Mid-window reset, then a zero-length window; start in DONE is ignored.
    add("f_start",      0, 1, 5, 10,   0, 10, 10, 10,    1,   1,  0, 0,  3'b000, 0, 0, 0, 0);
    add("f_b1",         0, 0, 0, 10,   1, 10, 10, 10,    1,   1,  1, 1,  3'b111, 1, 1, 1, 0);
    add("f_b2",         0, 0, 0, 10,   1, 10, 10, 10,    1,   1,  1, 1,  3'b111, 2, 2, 2, 0);
    add("f_rst",        1, 0, 0, 10,   1, 10, 10, 10,    0,   0,  0, 1,  3'b000, 0, 0, 0, 0);
    add("f_post_rst",   0, 0, 0, 10,   1, 10, 10, 10,    0,   0,  0, 1,  3'b000, 0, 0, 0, 0);
    add("f_zero_start", 0, 1, 0, 10,   1, 10, 10, 10,    1,   0,  0, 0,  3'b000, 0, 0, 0, 1);
    add("f_done_start", 0, 1, 3, 10,   0, 10, 10, 10,    0,   0,  0, 0,  3'b000, 0, 0, 0, 0);
    add("f_idle",       0, 0, 3, 10,   0, 10, 10, 10,    0,   0,  0, 0,  3'b000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      start     = vecs[i].start;
      num_steps = vecs[i].ns;
      threshold = vecs[i].thr;
      in_valid  = vecs[i].vld;
      current   = vecs[i].cur;
      tick();
      check({vecs[i].name, ".busy"},        busy,        vecs[i].busy);
      check({vecs[i].name, ".in_ready"},    in_ready,    vecs[i].rdy);
      check({vecs[i].name, ".spike_valid"}, spike_valid, vecs[i].sv);
      check({vecs[i].name, ".counts"},      counts,      vecs[i].cnt);
      check({vecs[i].name, ".done"},        done,        vecs[i].done);
      if (vecs[i].chk_spk) check({vecs[i].name, ".spikes"}, spikes, vecs[i].spk);
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;

    // Two-bit spike counter saturates at 3 over six firing beats.
    s_start = 1'b1; s_num_steps = 8'd6; s_threshold = 16'd1;
    tick();
    check("sat.start_busy", s_busy, 1'b1);
    s_start = 1'b0; s_in_valid = 1'b1; s_current = 16'd5;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("sat.b%0d.counts", k + 1), s_counts, (k < 3) ? 2'(k + 1) : 2'd3);
      check($sformatf("sat.b%0d.spikes", k + 1), s_spikes, 1'b1);
      check($sformatf("sat.b%0d.done", k + 1),   s_done,   (k == 5));
    end
    s_in_valid = 1'b0;
    tick();
    check("sat.idle_busy",   s_busy,   1'b0);
    check("sat.idle_counts", s_counts, 2'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
